// File: rtl/apb_master_arbiter.sv
// Round-robin arbiter sharing one APB bridge master between NREQ requesters.
// Captures the winner's request, drives the bridge and returns status/data.
module apb_master_arbiter #(
  parameter int NREQ    = 4,
  parameter int ADDR_W  = 33,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                     PCLK,
  input  logic                     PRESET,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ-1:0]          req_write,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_wdata,
  output logic [NREQ-1:0]          req_grant,
  output logic [NREQ-1:0]          req_done,
  output logic [DATA_W-1:0]        req_rdata,
  output logic                     req_err,
  output logic                     transfer,
  output logic                     READ_WRITE,
  output logic [ADDR_W-1:0]        apb_write_paddr,
  output logic [ADDR_W-1:0]        apb_read_paddr,
  output logic [DATA_W-1:0]        apb_write_data,
  input  logic                     PENABLE,
  input  logic                     PREADY,
  input  logic                     PSLVERR,
  input  logic [DATA_W-1:0]        PRDATA
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [NREQ-1:0] ONE = NREQ'(1);

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_BUSY,
    ARB_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [IW-1:0]       ptr_q;
  logic [CW-1:0]       cnt_q;
  logic [NREQ-1:0]     grant_q, done_q;
  logic [DATA_W-1:0]   rdata_q, wdata_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                write_q, err_q;

  logic [IW-1:0]       win_idx, cand;
  logic                any_valid;
  logic                busy, ok, tmo, fin;

  // First valid requester strictly after the pointer, wrapping around.
  always_comb begin
    win_idx   = '0;
    cand      = '0;
    any_valid = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IW'((int'(ptr_q) + k) % NREQ);
      if (!any_valid && req_valid[cand]) begin
        any_valid = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign busy = (state_q == ARB_BUSY);
  assign ok   = PENABLE && PREADY;
  assign tmo  = (cnt_q == CW'(TIMEOUT - 1));
  assign fin  = busy && (ok || PSLVERR || tmo);

  always_ff @(posedge PCLK) begin
    if (PRESET) state_q <= ARB_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARB_IDLE: if (any_valid) state_d = ARB_BUSY;
      ARB_BUSY: if (fin)       state_d = ARB_DONE;
      ARB_DONE:                state_d = ARB_IDLE;
      default:                 state_d = ARB_IDLE;
    endcase
  end

  // Combinational so the bridge sees transfer low in the completion cycle.
  always_comb begin
    transfer        = busy && !ok && !PSLVERR && !tmo;
    READ_WRITE      = busy && !write_q;
    apb_write_paddr = addr_q;
    apb_read_paddr  = addr_q;
    apb_write_data  = wdata_q;
    req_grant       = grant_q;
    req_done        = done_q;
    req_rdata       = rdata_q;
    req_err         = err_q;
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      ptr_q   <= IW'(NREQ - 1);
      cnt_q   <= '0;
      grant_q <= '0;
      done_q  <= '0;
      rdata_q <= '0;
      wdata_q <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        ARB_IDLE: begin
          if (any_valid) begin
            grant_q <= ONE << win_idx;
            ptr_q   <= win_idx;
            addr_q  <= req_addr[int'(win_idx)*ADDR_W +: ADDR_W];
            wdata_q <= req_wdata[int'(win_idx)*DATA_W +: DATA_W];
            write_q <= req_write[win_idx];
            cnt_q   <= '0;
          end
        end
        ARB_BUSY: begin
          if (fin) begin
            done_q  <= grant_q;
            rdata_q <= (!write_q && ok && !PSLVERR) ? PRDATA : '0;
            err_q   <= PSLVERR || (tmo && !ok);
            cnt_q   <= '0;
          end else begin
            cnt_q   <= cnt_q + CW'(1);
          end
        end
        ARB_DONE: begin
          grant_q <= '0;
          done_q  <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
